// File: rtl/cv32e41s_tcm_banked.sv
// Multi-port, word-interleaved, multi-bank TCM for cv32e41s.
// Per-bank round-robin arbitration; out-of-range accesses answer with err.
module cv32e41s_tcm_banked #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_BANKS = 2,
    parameter int MEM_WORDS = 1024,
    parameter int D_WID     = 32,
    parameter int A_WID     = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [NUM_PORTS-1:0]         we_i,
    input  logic [NUM_PORTS*D_WID/8-1:0] be_i,
    input  logic [NUM_PORTS*A_WID-1:0]   addr_i,
    input  logic [NUM_PORTS*D_WID-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]         gnt_o,
    output logic [NUM_PORTS-1:0]         rvalid_o,
    output logic [NUM_PORTS*D_WID-1:0]   rdata_o,
    output logic [NUM_PORTS-1:0]         err_o
);

    localparam int BW   = D_WID / 8;
    localparam int W    = $clog2(BW);
    localparam int B    = $clog2(NUM_BANKS);
    localparam int BI   = (B > 0) ? B : 1;
    localparam int ROWS = MEM_WORDS / NUM_BANKS;
    localparam int RI   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PI   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [BI-1:0] BMASK = BI'(NUM_BANKS - 1);

    logic [D_WID-1:0] r_mem [NUM_BANKS][ROWS];

    logic [A_WID-1:0]     w_word [NUM_PORTS];
    logic [BI-1:0]        w_bank [NUM_PORTS];
    logic [RI-1:0]        w_row  [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_inr;
    logic [NUM_BANKS-1:0] w_hit  [NUM_PORTS];

    logic [NUM_BANKS-1:0] w_win_vld;
    logic [PI-1:0]        w_win [NUM_BANKS];
    logic [PI-1:0]        r_ptr [NUM_BANKS];

    logic [NUM_PORTS-1:0] w_gnt;

    logic [NUM_PORTS-1:0]            r_rvalid;
    logic [NUM_PORTS-1:0]            r_err;
    logic [NUM_PORTS-1:0][D_WID-1:0] r_rdata;

    // Per-port address decode into bank, row and range check
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_word[p] = addr_i[p*A_WID +: A_WID] >> W;
            w_bank[p] = w_word[p][BI-1:0] & BMASK;
            w_row[p]  = RI'(w_word[p] >> B);
            w_inr[p]  = (w_word[p] < A_WID'(MEM_WORDS));
            for (int b = 0; b < NUM_BANKS; b++) begin
                w_hit[p][b] = req_i[p] & w_inr[p] & (w_bank[p] == BI'(b));
            end
        end
    end

    // Per-bank round-robin pick: first hit at or after the pointer
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_win_vld[b] = 1'b0;
            w_win[b]     = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                int idx;
                idx = int'(r_ptr[b]) + i;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!w_win_vld[b] && w_hit[idx][b]) begin
                    w_win_vld[b] = 1'b1;
                    w_win[b]     = PI'(idx);
                end
            end
        end
    end

    // Out-of-range requests bypass arbitration; nothing is granted in reset
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_gnt[p] = rst_ni & req_i[p] &
                       (~w_inr[p] |
                        (w_win_vld[w_bank[p]] &
                         (w_win[w_bank[p]] == PI'(p))));
        end
    end

    // Byte-masked writes into the banks; contents survive reset
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < BW; k++) begin
                if (w_gnt[p] && w_inr[p] && we_i[p] && be_i[p*BW + k]) begin
                    r_mem[w_bank[p]][w_row[p]][k*8 +: 8] <=
                        wdata_i[p*D_WID + k*8 +: 8];
                end
            end
        end
    end

    // Registered responses and round-robin pointer advance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_ptr[b] <= '0;
            end
        end else begin
            r_rvalid <= w_gnt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gnt[p]) begin
                    r_err[p] <= ~w_inr[p];
                    if (w_inr[p] && !we_i[p]) begin
                        r_rdata[p] <= r_mem[w_bank[p]][w_row[p]];
                    end else begin
                        r_rdata[p] <= '0;
                    end
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_win_vld[b]) begin
                    if (w_win[b] == PI'(NUM_PORTS - 1)) begin
                        r_ptr[b] <= '0;
                    end else begin
                        r_ptr[b] <= w_win[b] + 1'b1;
                    end
                end
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;

endmodule

// File: tb/tb_cv32e41s_tcm_banked.sv
// Directed bench for cv32e41s_tcm_banked (2 ports, 2 banks, 1024 words).
// Stimulus queues expected responses; a monitor checks them on rvalid.
module tb_cv32e41s_tcm_banked;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [7:0]  be_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [63:0] rdata_o;
    logic [1:0]  err_o;

    cv32e41s_tcm_banked #(
        .NUM_PORTS(2),
        .NUM_BANKS(2),
        .MEM_WORDS(1024),
        .D_WID(32),
        .A_WID(32)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .we_i(we_i),
        .be_i(be_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .err_o(err_o)
    );

    typedef struct packed {
        int          stamp;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_port(input int p);
        exp_t e;
        logic [31:0] d;
        d = rdata_o[p*32 +: 32];
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid p%0d: got rvalid=1 expected 0", p);
        end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rv_cycle p%0d", p), 64'(cyc), 64'(e.stamp + 1));
            chk($sformatf("err p%0d", p), 64'(err_o[p]), 64'(e.err));
            chk($sformatf("rdata p%0d", p), 64'(d), 64'(e.data));
        end
    endtask

    // Monitor: every response is matched against the queued expectation
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rvalid_o[0]) mon_port(0);
            if (rvalid_o[1]) mon_port(1);
        end
    end

    task automatic set(input int p, input logic rq, input logic w,
                       input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd);
        req_i[p]           = rq;
        we_i[p]            = w;
        be_i[p*4 +: 4]     = be;
        addr_i[p*32 +: 32] = a;
        wdata_i[p*32 +: 32] = wd;
    endtask

    task automatic step(input logic [1:0] eg,
                        input logic e0err, input logic [31:0] e0d,
                        input logic e1err, input logic [31:0] e1d);
        exp_t e;
        @(negedge clk_i);
        chk("gnt", 64'(gnt_o), 64'(eg));
        if (eg[0]) begin
            e.stamp = cyc; e.err = e0err; e.data = e0d;
            q0.push_back(e);
        end
        if (eg[1]) begin
            e.stamp = cyc; e.err = e1err; e.data = e1d;
            q1.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        set(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set(1, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        set(0, 1, 0, 4'hF, 32'h0, 32'h0);
        set(1, 1, 0, 4'hF, 32'h4, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_rvalid", 64'(rvalid_o), 64'h0);
        chk("reset_err", 64'(err_o), 64'h0);
        chk("reset_rdata", rdata_o, 64'h0);
        chk("reset_gnt", 64'(gnt_o), 64'h0);
        idle();
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Seed word 0 from port 1; bank0 pointer wraps back to 0
        set(1, 1, 1, 4'hF, 32'h0, 32'hCAFEF00D);
        step(2'b10, 0, 0, 0, 32'h0);

        // Same-bank conflict: p0, p1, p0, then held p1 is served
        set(0, 1, 0, 4'hF, 32'h0, 32'h0);
        set(1, 1, 0, 4'hF, 32'h0, 32'h0);
        step(2'b01, 0, 32'hCAFEF00D, 0, 0);
        step(2'b10, 0, 0, 0, 32'hCAFEF00D);
        step(2'b01, 0, 32'hCAFEF00D, 0, 0);
        set(0, 0, 0, 4'h0, 32'h0, 32'h0);
        step(2'b10, 0, 0, 0, 32'hCAFEF00D);
        idle();

        // Single port write then read back
        set(0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        step(2'b01, 0, 32'h0, 0, 0);
        set(0, 1, 0, 4'hF, 32'h10, 32'h0);
        step(2'b01, 0, 32'hDEADBEEF, 0, 0);
        idle();
        set(1, 1, 1, 4'hF, 32'h4, 32'h01020304);
        step(2'b10, 0, 0, 0, 32'h0);

        // Different banks in the same cycle
        set(0, 1, 0, 4'hF, 32'h0, 32'h0);
        set(1, 1, 0, 4'hF, 32'h4, 32'h0);
        step(2'b11, 0, 32'hCAFEF00D, 0, 32'h01020304);
        idle();

        // Byte enables
        set(1, 1, 1, 4'hF, 32'h20, 32'h11223344);
        step(2'b10, 0, 0, 0, 32'h0);
        set(1, 1, 1, 4'b0101, 32'h20, 32'hAABBCCDD);
        step(2'b10, 0, 0, 0, 32'h0);
        set(1, 1, 0, 4'hF, 32'h20, 32'h0);
        step(2'b10, 0, 0, 0, 32'h11BB33DD);
        idle();
        set(0, 1, 1, 4'h0, 32'h10, 32'hFFFFFFFF);
        step(2'b01, 0, 32'h0, 0, 0);
        set(0, 1, 0, 4'hF, 32'h10, 32'h0);
        step(2'b01, 0, 32'hDEADBEEF, 0, 0);

        // Out-of-range alongside an in-range access to bank0
        set(0, 1, 0, 4'hF, 32'h1000, 32'h0);
        set(1, 1, 0, 4'hF, 32'h0, 32'h0);
        step(2'b11, 1, 32'h0, 0, 32'hCAFEF00D);
        idle();
        set(0, 1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF);
        step(2'b01, 1, 32'h0, 0, 0);
        set(0, 1, 0, 4'hF, 32'h0, 32'h0);
        step(2'b01, 0, 32'hCAFEF00D, 0, 0);
        idle();

        // Highest in-range word
        set(1, 1, 1, 4'hF, 32'hFFC, 32'h5A5A0FFC);
        step(2'b10, 0, 0, 0, 32'h0);
        set(1, 1, 0, 4'hF, 32'hFFC, 32'h0);
        step(2'b10, 0, 0, 0, 32'h5A5A0FFC);
        idle();
        step(2'b00, 0, 0, 0, 0);

        // Reset right after a grant drops the response and the pointer
        set(0, 1, 0, 4'hF, 32'h0, 32'h0);
        @(negedge clk_i);
        chk("pre_reset_gnt", 64'(gnt_o), 64'h1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_rvalid_now", 64'(rvalid_o), 64'h0);
        @(posedge clk_i);
        #1;
        chk("rst_rvalid_edge", 64'(rvalid_o), 64'h0);
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        set(1, 1, 0, 4'hF, 32'h0, 32'h0);
        rst_ni = 1'b1;
        step(2'b01, 0, 32'hCAFEF00D, 0, 0);
        step(2'b10, 0, 0, 0, 32'hCAFEF00D);
        idle();
        step(2'b00, 0, 0, 0, 0);
        step(2'b00, 0, 0, 0, 0);

        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
